// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - pipeline and SRAM signal bundle for mem_stage_sram_ctrl
// addr_err exists only when SRAM_RANGE_CHECK_EN is defined.
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        ALU_result;
  logic [31:0]        Rm;
  logic [31:0]        read_data;
  logic               ready;
  logic               freeze;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;
`ifdef SRAM_RANGE_CHECK_EN
  logic               addr_err;

  modport slave (
    input  mem_read, mem_write, ALU_result, Rm, sram_dq_in,
    output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, addr_err
  );
  modport master (
    output mem_read, mem_write, ALU_result, Rm, sram_dq_in,
    input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, addr_err
  );
`else
  modport slave (
    input  mem_read, mem_write, ALU_result, Rm, sram_dq_in,
    output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport master (
    output mem_read, mem_write, ALU_result, Rm, sram_dq_in,
    input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
`endif
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage 32-bit access over a 16-bit async SRAM in two half-word phases
// Optional address checking is enabled by defining SRAM_RANGE_CHECK_EN.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 3
) (
  input logic                  clk,
  input logic                  reset,
  mem_stage_sram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int         WW   = SRAM_AW - 1;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            start;
  logic            req, req_wr, bad;
  logic [WW-1:0]   req_word, word_q, cur_word;
  logic            wr_q, cur_wr;
  logic [31:0]     wdata_q, cur_wdata, rdata;
  logic            active_n, oe_n, we_n_n, oe_q, we_n_q;
  logic [SRAM_AW-1:0] addr_n, addr_q;
  logic [15:0]     dq_n, dq_q;

  assign req      = bus.mem_read | bus.mem_write;
  assign req_wr   = bus.mem_write;
  assign req_word = WW'((bus.ALU_result - 32'(BASE_ADDR)) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
  localparam logic [31:0] MAX_WORD = 32'((64'd1 << WW) - 64'd1);
  logic err_q;

  assign bad = (bus.ALU_result < 32'(BASE_ADDR)) || (bus.ALU_result[1:0] != 2'b00) ||
               (((bus.ALU_result - 32'(BASE_ADDR)) >> 2) > MAX_WORD);
  assign bus.addr_err = err_q & (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (start) err_q <= bad;
  end
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    case (state)
      IDLE: if (req) begin
        start   = 1'b1;
        state_n = bad ? DONE : LOW;
      end
      LOW: if (cnt == LAST) begin
        state_n = HIGH;
        cnt_n   = '0;
      end else cnt_n = cnt + 4'd1;
      HIGH: if (cnt == LAST) begin
        state_n = DONE;
        cnt_n   = '0;
      end else cnt_n = cnt + 4'd1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operation is latched at acceptance so a flush dropping req cannot disturb the bus.
  assign cur_wr    = (state == IDLE) ? req_wr   : wr_q;
  assign cur_word  = (state == IDLE) ? req_word : word_q;
  assign cur_wdata = (state == IDLE) ? bus.Rm   : wdata_q;

  // Bus outputs are registered from next-state so strobes are glitch-free.
  always_comb begin
    active_n = (state_n == LOW) || (state_n == HIGH);
    addr_n   = active_n ? {cur_word, state_n == HIGH} : '0;
    oe_n     = active_n & cur_wr;
    dq_n     = oe_n ? ((state_n == HIGH) ? cur_wdata[31:16] : cur_wdata[15:0]) : 16'h0000;
    we_n_n   = ~(oe_n & (cnt_n != LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      dq_q   <= dq_n;
      oe_q   <= oe_n;
      we_n_q <= we_n_n;
      if (start) begin
        wr_q    <= req_wr;
        word_q  <= req_word;
        wdata_q <= bus.Rm;
      end
      if (!wr_q && cnt == LAST) begin
        if (state == LOW)  rdata[15:0]  <= bus.sram_dq_in;
        if (state == HIGH) rdata[31:16] <= bus.sram_dq_in;
      end
      if (start && bad && !req_wr) rdata <= '0;
    end
  end

  assign bus.ready       = (state == DONE);
  assign bus.freeze      = req & ~bus.ready;
  assign bus.read_data   = rdata;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench for mem_stage_sram_ctrl with SRAM device and word-level model
module tb_mem_stage_sram_ctrl;
  localparam int W    = 3;
  localparam int AW   = 18;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.SRAM_AW(AW)) bus ();

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // External asynchronous SRAM device
  bit [15:0] sram [0:(1<<AW)-1];
  assign bus.sram_dq_in = sram[bus.sram_addr];
  always @(posedge clk) if (reset && !bus.sram_we_n) sram[bus.sram_addr] <= bus.sram_dq_out;

  typedef struct {
    bit          store;
    bit          err;
    int          word;
    logic [31:0] sdata;
    logic [31:0] rd;
    int          frz;
    int          we;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          frz_cnt = 0;
  int          we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge reset) begin
    frz_cnt = 0;
    we_cnt  = 0;
  end

  always @(negedge clk) if (reset) begin
    exp_t e;
    if (bus.freeze) frz_cnt++;
    if (!bus.sram_we_n) begin
      we_cnt++;
      check("oe_during_we", bus.sram_dq_oe, 1);
      if (sb.size() > 0) check("we_word_addr", 32'(bus.sram_addr >> 1), sb[0].word);
    end
    if (bus.ready) begin
      if (sb.size() == 0) check("unexpected_ready", 1, 0);
      else begin
        e = sb.pop_front();
        check("read_data", bus.read_data, e.rd);
        check("freeze_cycles", frz_cnt, e.frz);
        check("we_low_cycles", we_cnt, e.we);
`ifdef SRAM_RANGE_CHECK_EN
        check("addr_err", bus.addr_err, e.err);
`endif
        if (e.store) check("sram_word", {sram[2*e.word+1], sram[2*e.word]}, e.sdata);
      end
      frz_cnt = 0;
      we_cnt  = 0;
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.ALU_result = addr;
    bus.Rm         = data;
    e.word  = int'((addr - BASE) >> 2);
    e.sdata = data;
    e.store = 1'b0;
    e.err   = 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
    e.err = (addr < BASE) || (addr[1:0] != 2'b00) || (((addr - BASE) >> 2) > ((1 << (AW-1)) - 1));
`endif
    if (e.err) begin
      e.frz = 1;
      e.we  = 0;
      if (!wr) last_rd = 32'h0;
    end else if (wr) begin
      ref_mem[e.word] = data;
      e.store = 1'b1;
      e.frz   = 2*W + 1;
      e.we    = 2*(W-1);
    end else begin
      last_rd = ref_mem.exists(e.word) ? ref_mem[e.word] : 32'h0;
      e.frz   = 2*W + 1;
      e.we    = 0;
    end
    e.rd = last_rd;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 100);
    if (!bus.ready) check("ready_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    bit ready_seen;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ALU_result = 32'h0;
    bus.Rm         = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_freeze", bus.freeze, 0);
    check("rst_we_n", bus.sram_we_n, 1);
    check("rst_oe", bus.sram_dq_oe, 0);
    check("rst_addr", 32'(bus.sram_addr), 0);
    check("rst_dq_out", bus.sram_dq_out, 0);
    check("rst_read_data", bus.read_data, 0);
`ifdef SRAM_RANGE_CHECK_EN
    check("rst_addr_err", bus.addr_err, 0);
`endif
    reset = 1'b1;

    access(0, 1, 1024, 32'hDEADBEEF);
    idle(2);
    access(0, 1, 1028, 32'h12345678);
    idle(1);
    access(1, 0, 1024, 32'h0);
    access(1, 0, 1028, 32'h0);
    access(0, 1, 1032, 32'hCAFEF00D);
    access(1, 1, 1036, 32'hA5A55A5A);
    idle(2);
    access(1, 0, 1036, 32'h0);
    idle(1);

    // Abort a store mid-HIGH with an asynchronous reset
    @(posedge clk); #1;
    bus.mem_write  = 1'b1;
    bus.ALU_result = 32'd1824;
    bus.Rm         = $urandom;
    repeat (6) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_we_n", bus.sram_we_n, 1);
    check("abort_oe", bus.sram_dq_oe, 0);
    check("abort_ready", bus.ready, 0);
    check("abort_read_data", bus.read_data, 0);
    bus.mem_write = 1'b0;
    last_rd = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    ready_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.ready) ready_seen = 1'b1;
    end
    check("abort_no_ready", 32'(ready_seen), 0);

    for (int i = 0; i < 40; i++) begin
      int op;
      int w;
      op = $urandom_range(0, 2);
      w  = $urandom_range(0, 63);
      access(op != 1, op != 0, 32'(BASE + 4*w), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

`ifdef SRAM_RANGE_CHECK_EN
    idle(1);
    access(1, 0, 1000, 32'h0);
    idle(1);
    access(1, 0, 1026, 32'h0);
`endif
    idle(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
